// File: rtl/instruction_memory_responder_if.sv
// Fetch-side request/response bus plus the preload write port of the
// instruction memory responder. The fetch stage (or bench) is the master.
interface instruction_memory_responder_if;
   logic        request_valid;
   logic        request_ready;
   logic [31:0] memory_address;
   logic        flush;
   logic [31:0] memory_data;
   logic        response_valid;
   logic        response_error;
   logic        load_enable;
   logic [31:0] load_address;
   logic [31:0] load_data;

   modport master (
      output request_valid, memory_address, flush, load_enable, load_address, load_data,
      input  request_ready, memory_data, response_valid, response_error
   );

   modport slave (
      input  request_valid, memory_address, flush, load_enable, load_address, load_data,
      output request_ready, memory_data, response_valid, response_error
   );
endinterface

// File: rtl/instruction_memory_responder.sv
// Multi-cycle instruction memory responder. A fetch request is accepted only
// when idle; the addressed word is captured at acceptance and presented with a
// one-cycle response_valid pulse LATENCY edges later. Misaligned or
// out-of-range addresses answer after one edge with response_error set and
// zero data. A flush aborts an in-flight request without any response.
// A preload port writes the array in any state; the array is never reset.
module instruction_memory_responder #(
   parameter int NUM_WORDS     = 64,
   parameter int LATENCY       = 2,
   parameter int COUNTER_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   instruction_memory_responder_if.slave bus
);

   localparam int                       INDEX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [29:0]              WORD_LIMIT  = 30'(NUM_WORDS);
   localparam logic [COUNTER_WIDTH-1:0] WAIT_COUNT  = COUNTER_WIDTH'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESPOND
   } state_t;

   state_t                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
   logic [31:0]              held_data_q, held_data_d;
   logic                     held_error_q, held_error_d;
   logic [31:0]              memory_data_q, memory_data_d;
   logic                     response_valid_q, response_valid_d;
   logic                     response_error_q, response_error_d;

   logic [31:0]              mem [NUM_WORDS];

   logic [29:0]              request_index;
   logic                     request_error;
   logic [31:0]              request_word;
   logic                     accept;
   logic [29:0]              load_index;
   logic                     load_ok;

   assign request_index  = bus.memory_address[31:2];
   assign request_error  = (bus.memory_address[1:0] != 2'b00) || (request_index >= WORD_LIMIT);
   assign request_word   = request_error ? 32'h0 : mem[request_index[INDEX_WIDTH-1:0]];
   assign bus.request_ready = (state_q == IDLE) && !bus.flush;
   assign accept         = bus.request_valid && bus.request_ready;

   assign load_index     = bus.load_address[31:2];
   assign load_ok        = bus.load_enable && (bus.load_address[1:0] == 2'b00) &&
                           (load_index < WORD_LIMIT);

   assign bus.memory_data    = memory_data_q;
   assign bus.response_valid = response_valid_q;
   assign bus.response_error = response_error_q;

   // Next-state logic: every accepted request waits in WAIT until the counter
   // has run out, so errors (counter 0) answer one edge later and good reads
   // LATENCY edges later; flush wins over both acceptance and expiry.
   always_comb begin
      state_d          = state_q;
      counter_d        = counter_q;
      held_data_d      = held_data_q;
      held_error_d     = held_error_q;
      memory_data_d    = memory_data_q;
      response_valid_d = 1'b0;
      response_error_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d      = WAIT;
               held_data_d  = request_word;
               held_error_d = request_error;
               counter_d    = request_error ? '0 : WAIT_COUNT;
            end
         end
         WAIT: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else if (counter_q == '0) begin
               state_d          = RESPOND;
               response_valid_d = 1'b1;
               response_error_d = held_error_q;
               memory_data_d    = held_data_q;
            end else begin
               counter_d = counter_q - 1'b1;
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers; reset drops any in-flight request at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         counter_q        <= '0;
         held_data_q      <= 32'h0;
         held_error_q     <= 1'b0;
         memory_data_q    <= 32'h0;
         response_valid_q <= 1'b0;
         response_error_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         counter_q        <= counter_d;
         held_data_q      <= held_data_d;
         held_error_q     <= held_error_d;
         memory_data_q    <= memory_data_d;
         response_valid_q <= response_valid_d;
         response_error_q <= response_error_d;
      end
   end

   // Preload write port; the array keeps its contents across reset, and a read
   // accepted on the same edge sees the word as it was before this write.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         mem[load_index[INDEX_WIDTH-1:0]] <= bus.load_data;
      end
   end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench for instruction_memory_responder: directed scenarios and
// random traffic compared against a transaction-level reference model.
module tb_instruction_memory_responder;

   localparam int NUM_WORDS     = 64;
   localparam int LATENCY       = 2;
   localparam int COUNTER_WIDTH = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   instruction_memory_responder_if bus ();

   instruction_memory_responder #(
      .NUM_WORDS    (NUM_WORDS),
      .LATENCY      (LATENCY),
      .COUNTER_WIDTH(COUNTER_WIDTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: memory image plus the timeline of the one outstanding request.
   logic [31:0] model_mem [NUM_WORDS];
   bit          m_busy;
   int          edge_num;
   int          m_resp_edge;
   int          m_done_edge;
   logic [31:0] m_pdata;
   bit          m_perr;

   logic        exp_valid, exp_err, exp_ready, obs_ready;
   logic [31:0] exp_data;

   function automatic bit addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (int'(a[31:2]) >= NUM_WORDS);
   endfunction

   // Advance the model by one rising edge with the inputs that were sampled there.
   task automatic model_edge(input logic rv, input logic [31:0] addr, input logic fl,
                             input logic le, input logic [31:0] la, input logic [31:0] ld);
      edge_num++;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (m_busy) begin
         if (fl || edge_num == m_done_edge) begin
            m_busy = 1'b0;
         end else if (edge_num == m_resp_edge) begin
            exp_valid = 1'b1;
            exp_err   = m_perr;
            exp_data  = m_pdata;
         end
      end else if (rv && !fl) begin
         m_busy      = 1'b1;
         m_perr      = addr_bad(addr);
         m_pdata     = m_perr ? 32'h0 : model_mem[int'(addr[31:2])];
         m_resp_edge = edge_num + (m_perr ? 1 : LATENCY);
         m_done_edge = m_resp_edge + 1;
      end
      if (le && !addr_bad(la)) model_mem[int'(la[31:2])] = ld;
   endtask

   // Drive one cycle of inputs just after a falling edge, sample ready, cross the
   // rising edge, update the model and return on the next falling edge.
   task automatic step(input logic rv, input logic [31:0] addr, input logic fl,
                       input logic le, input logic [31:0] la, input logic [31:0] ld);
      bus.request_valid  = rv;
      bus.memory_address = addr;
      bus.flush          = fl;
      bus.load_enable    = le;
      bus.load_address   = la;
      bus.load_data      = ld;
      #1;
      obs_ready = bus.request_ready;
      exp_ready = !m_busy && !fl;
      @(posedge clk);
      model_edge(rv, addr, fl, le, la, ld);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.request_valid = 1'b0; bus.memory_address = '0; bus.flush = 1'b0;
      bus.load_enable = 1'b0; bus.load_address = '0; bus.load_data = '0;
      m_busy = 1'b0; edge_num = 0; exp_valid = 1'b0; exp_err = 1'b0; exp_data = 32'h0;
      repeat (2) @(negedge clk);
      checks += 4;
      if (bus.response_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.response_valid); end
      if (bus.response_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", bus.response_error); end
      if (bus.memory_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.memory_data); end
      if (bus.request_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.request_ready); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic preload_all();
      for (int i = 0; i < NUM_WORDS; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), $urandom);
   endtask

   task automatic test_basic();
      step(1'b0, 0, 1'b0, 1'b1, 32'h10, 32'h0000_0013);
      step(1'b0, 0, 1'b0, 1'b1, 32'h14, 32'h0010_0093);
      for (int i = 0; i < 5; i++) begin
         step(i == 0, 32'h10, 1'b0, 1'b0, 0, 0);
         checks += 6;
         if (obs_ready !== exp_ready) begin errors++; $display("FAIL basic_ready c%0d got %b exp %b", i, obs_ready, exp_ready); end
         if (bus.response_valid !== exp_valid) begin errors++; $display("FAIL basic_valid c%0d got %b exp %b", i, bus.response_valid, exp_valid); end
         if (bus.response_error !== exp_err) begin errors++; $display("FAIL basic_error c%0d got %b exp %b", i, bus.response_error, exp_err); end
         if (bus.memory_data !== exp_data) begin errors++; $display("FAIL basic_data c%0d got %h exp %h", i, bus.memory_data, exp_data); end
         if (bus.response_valid !== (i == 2)) begin errors++; $display("FAIL basic_pulse_time c%0d got %b exp %b", i, bus.response_valid, (i == 2)); end
         if (i == 2 && bus.memory_data !== 32'h0000_0013) begin errors++; $display("FAIL basic_word got %h exp 00000013", bus.memory_data); end
      end
   endtask

   task automatic test_errors();
      logic [31:0] bad_addr [2];
      bad_addr[0] = 32'h12;
      bad_addr[1] = 32'h100;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            step(i == 0, bad_addr[r], 1'b0, 1'b0, 0, 0);
            checks += 5;
            if (obs_ready !== exp_ready) begin errors++; $display("FAIL err_ready a%h c%0d got %b exp %b", bad_addr[r], i, obs_ready, exp_ready); end
            if (bus.response_valid !== exp_valid) begin errors++; $display("FAIL err_valid a%h c%0d got %b exp %b", bad_addr[r], i, bus.response_valid, exp_valid); end
            if (bus.response_error !== exp_err) begin errors++; $display("FAIL err_flag a%h c%0d got %b exp %b", bad_addr[r], i, bus.response_error, exp_err); end
            if (bus.memory_data !== exp_data) begin errors++; $display("FAIL err_data a%h c%0d got %h exp %h", bad_addr[r], i, bus.memory_data, exp_data); end
            if ({bus.response_valid, bus.response_error} !== ((i == 1) ? 2'b11 : 2'b00)) begin
               errors++; $display("FAIL err_pulse_time a%h c%0d got %b%b", bad_addr[r], i, bus.response_valid, bus.response_error);
            end
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 10; i++) begin
         step(i == 0 || i == 4, (i < 4) ? 32'h14 : 32'h10, i == 1, 1'b0, 0, 0);
         checks += 4;
         if (obs_ready !== exp_ready) begin errors++; $display("FAIL flush_ready c%0d got %b exp %b", i, obs_ready, exp_ready); end
         if (bus.response_valid !== exp_valid) begin errors++; $display("FAIL flush_valid c%0d got %b exp %b", i, bus.response_valid, exp_valid); end
         if (bus.response_error !== exp_err) begin errors++; $display("FAIL flush_error c%0d got %b exp %b", i, bus.response_error, exp_err); end
         if (bus.memory_data !== exp_data) begin errors++; $display("FAIL flush_data c%0d got %h exp %h", i, bus.memory_data, exp_data); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr;
      int          accepts;
      addr    = 32'h10;
      accepts = 0;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, addr, 1'b0, 1'b0, 0, 0);
         if (exp_ready) begin
            accepts++;
            addr = (addr == 32'h10) ? 32'h14 : 32'h10;
         end
         checks += 4;
         if (obs_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready c%0d got %b exp %b", i, obs_ready, exp_ready); end
         if (bus.response_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid c%0d got %b exp %b", i, bus.response_valid, exp_valid); end
         if (bus.response_error !== exp_err) begin errors++; $display("FAIL b2b_error c%0d got %b exp %b", i, bus.response_error, exp_err); end
         if (bus.memory_data !== exp_data) begin errors++; $display("FAIL b2b_data c%0d got %h exp %h", i, bus.memory_data, exp_data); end
      end
      checks++;
      if (accepts < 4) begin errors++; $display("FAIL b2b_accept_count got %0d exp at least 4", accepts); end
      repeat (4) step(1'b0, 0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic test_load_during_wait();
      for (int i = 0; i < 10; i++) begin
         step(i == 0 || i == 4, 32'h10, 1'b0, i == 1, 32'h10, 32'hDEAD_BEEF);
         checks += 5;
         if (obs_ready !== exp_ready) begin errors++; $display("FAIL ldw_ready c%0d got %b exp %b", i, obs_ready, exp_ready); end
         if (bus.response_valid !== exp_valid) begin errors++; $display("FAIL ldw_valid c%0d got %b exp %b", i, bus.response_valid, exp_valid); end
         if (bus.response_error !== exp_err) begin errors++; $display("FAIL ldw_error c%0d got %b exp %b", i, bus.response_error, exp_err); end
         if (bus.memory_data !== exp_data) begin errors++; $display("FAIL ldw_data c%0d got %h exp %h", i, bus.memory_data, exp_data); end
         if (bus.response_valid && bus.memory_data !== ((i < 4) ? 32'h0000_0013 : 32'hDEAD_BEEF)) begin
            errors++; $display("FAIL ldw_word c%0d got %h", i, bus.memory_data);
         end
      end
   endtask

   task automatic test_same_edge_load();
      for (int i = 0; i < 5; i++) begin
         step(i == 0, 32'h14, 1'b0, i == 0, 32'h14, 32'hCAFE_F00D);
         checks += 4;
         if (obs_ready !== exp_ready) begin errors++; $display("FAIL same_ready c%0d got %b exp %b", i, obs_ready, exp_ready); end
         if (bus.response_valid !== exp_valid) begin errors++; $display("FAIL same_valid c%0d got %b exp %b", i, bus.response_valid, exp_valid); end
         if (bus.memory_data !== exp_data) begin errors++; $display("FAIL same_data c%0d got %h exp %h", i, bus.memory_data, exp_data); end
         if (i == 2 && bus.memory_data !== 32'h0010_0093) begin errors++; $display("FAIL same_old_word got %h exp 00100093", bus.memory_data); end
      end
   endtask

   task automatic test_random();
      logic [31:0] addr, la;
      logic        rv, fl, le;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0:       addr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            1:       addr = 32'($urandom_range(NUM_WORDS, 4000)) << 2;
            default: addr = 32'($urandom_range(0, NUM_WORDS - 1)) << 2;
         endcase
         la = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, NUM_WORDS - 1)) << 2);
         rv = ($urandom_range(0, 9) < 7);
         fl = ($urandom_range(0, 9) == 0);
         le = ($urandom_range(0, 4) == 0);
         step(rv, addr, fl, le, la, $urandom);
         checks += 4;
         if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", i, obs_ready, exp_ready); end
         if (bus.response_valid !== exp_valid) begin errors++; $display("FAIL rand_valid c%0d got %b exp %b", i, bus.response_valid, exp_valid); end
         if (bus.response_error !== exp_err) begin errors++; $display("FAIL rand_error c%0d got %b exp %b", i, bus.response_error, exp_err); end
         if (bus.memory_data !== exp_data) begin errors++; $display("FAIL rand_data c%0d got %h exp %h", i, bus.memory_data, exp_data); end
      end
      repeat (5) step(1'b0, 0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic test_async_reset();
      step(1'b0, 0, 1'b0, 1'b1, 32'h10, 32'h0000_0013);
      step(1'b0, 0, 1'b0, 1'b1, 32'h14, 32'h0010_0093);
      for (int i = 0; i < 4; i++) step(i == 0, 32'h14, 1'b0, 1'b0, 0, 0);
      step(1'b1, 32'h10, 1'b0, 1'b0, 0, 0);
      bus.request_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks += 4;
      if (bus.response_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", bus.response_valid); end
      if (bus.response_error !== 1'b0) begin errors++; $display("FAIL areset_error got %b exp 0", bus.response_error); end
      if (bus.memory_data !== 32'h0) begin errors++; $display("FAIL areset_data got %h exp 0", bus.memory_data); end
      if (bus.request_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b exp 1", bus.request_ready); end
      #1 reset = 1'b0;
      m_busy = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_data = 32'h0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         step(i == 0 || i == 4, (i < 4) ? 32'h10 : 32'h14, 1'b0, 1'b0, 0, 0);
         checks += 4;
         if (obs_ready !== exp_ready) begin errors++; $display("FAIL post_ready c%0d got %b exp %b", i, obs_ready, exp_ready); end
         if (bus.response_valid !== exp_valid) begin errors++; $display("FAIL post_valid c%0d got %b exp %b", i, bus.response_valid, exp_valid); end
         if (bus.memory_data !== exp_data) begin errors++; $display("FAIL post_data c%0d got %h exp %h", i, bus.memory_data, exp_data); end
         if (bus.response_valid && bus.memory_data !== ((i < 4) ? 32'h0000_0013 : 32'h0010_0093)) begin
            errors++; $display("FAIL post_word c%0d got %h", i, bus.memory_data);
         end
      end
   endtask

   initial begin
      $display("[TB] instruction_memory_responder bench starting");
      test_reset();
      preload_all();
      test_basic();
      test_errors();
      test_flush();
      test_back_to_back();
      test_load_during_wait();
      test_same_edge_load();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
